ahb_bus_arbiter: RTL and testbench

//  Round-robin AHB-Lite master arbiter in front of the shared slave (ahb_slave_bfm side).

---
 rtl/ahb_bus_arbiter.sv | 170 +++++++++++++++++
 tb/tb_ahb_bus_arbiter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB-Lite master arbiter: registered one-hot grant plus owner index,
// held across fixed bursts, undefined-length INCR bursts and locked sequences.
module ahb_bus_arbiter #(
  parameter int  NUM_MASTERS    = 4,
  parameter int  DEFAULT_MASTER = 0,
  localparam int MW             = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [NUM_MASTERS-1:0] hbusreq,
  input  logic [NUM_MASTERS-1:0] hlock,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY,
  input  logic                   HRESP,
  output logic [NUM_MASTERS-1:0] hgrant,
  output logic [MW-1:0]          hmaster,
  output logic                   hmastlock
);

  localparam logic [1:0] TR_IDLE   = 2'd0;
  localparam logic [1:0] TR_BUSY   = 2'd1;
  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;
  localparam logic [2:0] BU_SINGLE = 3'd0;
  localparam logic [2:0] BU_INCR   = 3'd1;
  localparam logic [MW-1:0]          DEF_IDX = MW'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] ONE_HOT = NUM_MASTERS'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_UNDEF, ST_LOCKED} state_e;

  state_e                 state_q, state_d;
  logic [3:0]             beats_q, beats_d;
  logic [MW-1:0]          rr_q, rr_d;
  logic [NUM_MASTERS-1:0] hgrant_q, hgrant_d;
  logic [MW-1:0]          hmaster_q, hmaster_d;
  logic                   hmastlock_q, hmastlock_d;

  logic [NUM_MASTERS-1:0] others_s;
  logic [MW-1:0]          scan_s;
  logic                   found_s;
  logic [MW-1:0]          win_s;
  logic                   arb_s;

  // Remaining SEQ beats after the NONSEQ of a fixed-length burst.
  function automatic logic [3:0] burst_beats(input logic [2:0] hburst);
    case (hburst)
      3'd2, 3'd3: burst_beats = 4'd3;
      3'd4, 3'd5: burst_beats = 4'd7;
      3'd6, 3'd7: burst_beats = 4'd15;
      default:    burst_beats = 4'd0;
    endcase
  endfunction

  // Round-robin winner search; the owner is masked so it only re-wins when alone.
  always_comb begin
    others_s            = hbusreq;
    others_s[hmaster_q] = 1'b0;
    found_s             = 1'b0;
    win_s               = DEF_IDX;
    scan_s              = rr_q;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      scan_s = (scan_s == MW'(NUM_MASTERS - 1)) ? '0 : scan_s + MW'(1);
      if (!found_s && others_s[scan_s]) begin
        found_s = 1'b1;
        win_s   = scan_s;
      end else begin
        found_s = found_s;
      end
    end
    if (!found_s && hbusreq[hmaster_q]) begin
      found_s = 1'b1;
      win_s   = hmaster_q;
    end else begin
      win_s = win_s;
    end
  end

  // Ownership FSM: decides arbitration points; HREADY low freezes everything.
  always_comb begin
    state_d     = state_q;
    beats_d     = beats_q;
    rr_d        = rr_q;
    hgrant_d    = hgrant_q;
    hmaster_d   = hmaster_q;
    hmastlock_d = hmastlock_q;
    arb_s       = 1'b0;
    if (HREADY) begin
      case (state_q)
        ST_IDLE: begin
          if (HTRANS == TR_NONSEQ && HBURST == BU_INCR) begin
            state_d = ST_UNDEF;
          end else if (HTRANS == TR_NONSEQ && HBURST != BU_SINGLE) begin
            state_d = ST_BURST;
            beats_d = burst_beats(HBURST);
          end else begin
            arb_s = 1'b1;
          end
        end
        ST_BURST: begin
          // The last SEQ beat's ready edge is the hand-off point.
          if (HRESP) begin
            arb_s = 1'b1;
          end else if (HTRANS == TR_SEQ) begin
            if (beats_q <= 4'd1) begin
              arb_s = 1'b1;
            end else begin
              beats_d = beats_q - 4'd1;
            end
          end else if (beats_q == 4'd0) begin
            arb_s = 1'b1;
          end else begin
            beats_d = beats_q;
          end
        end
        ST_UNDEF: begin
          if (HRESP || (!hbusreq[hmaster_q] && HTRANS != TR_SEQ && HTRANS != TR_BUSY)) begin
            arb_s = 1'b1;
          end else begin
            state_d = ST_UNDEF;
          end
        end
        ST_LOCKED: begin
          if (!hlock[hmaster_q] && HTRANS == TR_IDLE) begin
            arb_s = 1'b1;
          end else begin
            state_d = ST_LOCKED;
          end
        end
        default: arb_s = 1'b1;
      endcase
    end else begin
      arb_s = 1'b0;
    end
    if (arb_s) begin
      beats_d     = 4'd0;
      hmaster_d   = win_s;
      hgrant_d    = ONE_HOT << win_s;
      hmastlock_d = found_s && hlock[win_s];
      rr_d        = found_s ? win_s : rr_q;
      state_d     = (found_s && hlock[win_s]) ? ST_LOCKED : ST_IDLE;
    end else begin
      rr_d = rr_q;
    end
  end

  // State and output registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      beats_q     <= 4'd0;
      rr_q        <= DEF_IDX;
      hgrant_q    <= ONE_HOT << DEF_IDX;
      hmaster_q   <= DEF_IDX;
      hmastlock_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beats_q     <= beats_d;
      rr_q        <= rr_d;
      hgrant_q    <= hgrant_d;
      hmaster_q   <= hmaster_d;
      hmastlock_q <= hmastlock_d;
    end
  end

  assign hgrant    = hgrant_q;
  assign hmaster   = hmaster_q;
  assign hmastlock = hmastlock_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed bench for ahb_bus_arbiter: hand-computed grant/master/lock after each step.
module tb_ahb_bus_arbiter;

  logic       HCLK;
  logic       HRESETn;
  logic [3:0] hbusreq;
  logic [3:0] hlock;
  logic [1:0] HTRANS;
  logic [2:0] HBURST;
  logic       HREADY;
  logic       HRESP;
  logic [3:0] hgrant;
  logic [1:0] hmaster;
  logic       hmastlock;

  int checks = 0;
  int errors = 0;

  ahb_bus_arbiter #(.NUM_MASTERS(4), .DEFAULT_MASTER(0)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .hbusreq(hbusreq), .hlock(hlock),
    .HTRANS(HTRANS), .HBURST(HBURST), .HREADY(HREADY), .HRESP(HRESP),
    .hgrant(hgrant), .hmaster(hmaster), .hmastlock(hmastlock)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  // Compares {hgrant, hmaster, hmastlock} against owner index m and lock l.
  task automatic expect_owner(input string tag, input int m, input logic l);
    logic [6:0] obs;
    logic [6:0] exp;
    logic [3:0] g;
    g   = 4'b0001 << m;
    exp = {g, 2'(m), l};
    obs = {hgrant, hmaster, hmastlock};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed grant/master/lock=%b/%0d/%b expected=%b/%0d/%b",
             tag, obs[6:3], obs[2:1], obs[0], exp[6:3], exp[2:1], exp[0]);
    end
  endtask

  initial begin
    hbusreq = 4'b0000; hlock = 4'b0000; HTRANS = 2'd0; HBURST = 3'd0;
    HREADY = 1'b1; HRESP = 1'b0; HRESETn = 1'b0;

    // 1. reset and parking
    #12;
    expect_owner("reset", 0, 1'b0);
    #10 HRESETn = 1'b1;
    tick(); expect_owner("park0", 0, 1'b0);
    tick(); expect_owner("park1", 0, 1'b0);
    tick(); expect_owner("park2", 0, 1'b0);

    // 2. m1/m2 SINGLE requests alternate
    hbusreq = 4'b0110; HTRANS = 2'd2; HBURST = 3'd0;
    tick(); expect_owner("rr_a", 1, 1'b0);
    tick(); expect_owner("rr_b", 2, 1'b0);
    tick(); expect_owner("rr_c", 1, 1'b0);
    tick(); expect_owner("rr_d", 2, 1'b0);
    HREADY = 1'b0;
    tick(); expect_owner("rr_stall", 2, 1'b0);
    HREADY = 1'b1;

    // 3. m2 INCR4 with one beat stretched, m3 waiting; m2 drops req mid-burst
    hbusreq = 4'b1100; HTRANS = 2'd2; HBURST = 3'd3;
    tick(); expect_owner("incr4_b1", 2, 1'b0);
    hbusreq = 4'b1000; HTRANS = 2'd3;
    tick(); expect_owner("incr4_b2", 2, 1'b0);
    HREADY = 1'b0;
    tick(); expect_owner("incr4_w1", 2, 1'b0);
    tick(); expect_owner("incr4_w2", 2, 1'b0);
    HREADY = 1'b1;
    tick(); expect_owner("incr4_b3", 2, 1'b0);
    tick(); expect_owner("incr4_b4", 3, 1'b0);

    // 4. m1 undefined INCR holds while requesting
    hbusreq = 4'b0010; HTRANS = 2'd0; HBURST = 3'd0;
    tick(); expect_owner("undef_gnt", 1, 1'b0);
    hbusreq = 4'b0011; HTRANS = 2'd2; HBURST = 3'd1;
    tick(); expect_owner("undef_ns", 1, 1'b0);
    HTRANS = 2'd3;
    for (int i = 0; i < 9; i++) begin
      tick(); expect_owner("undef_hold", 1, 1'b0);
    end
    hbusreq = 4'b0001; HTRANS = 2'd0;
    tick(); expect_owner("undef_rel", 0, 1'b0);

    // 5. m3 locked sequence of two SINGLEs, m0 waiting
    hbusreq = 4'b1001; hlock = 4'b1000; HTRANS = 2'd0; HBURST = 3'd0;
    tick(); expect_owner("lock_gnt", 3, 1'b1);
    HTRANS = 2'd2;
    tick(); expect_owner("lock_s1", 3, 1'b1);
    tick(); expect_owner("lock_s2", 3, 1'b1);
    hlock = 4'b0000;
    tick(); expect_owner("lock_ns", 3, 1'b1);
    HTRANS = 2'd0;
    tick(); expect_owner("lock_rel", 0, 1'b0);

    // 6a. two-cycle ERROR on beat 2 of INCR8 aborts the burst
    hbusreq = 4'b0100; HTRANS = 2'd0;
    tick(); expect_owner("err_gnt", 2, 1'b0);
    hbusreq = 4'b0110; HTRANS = 2'd2; HBURST = 3'd5;
    tick(); expect_owner("err_b1", 2, 1'b0);
    HTRANS = 2'd3;
    tick(); expect_owner("err_b2", 2, 1'b0);
    HRESP = 1'b1; HREADY = 1'b0;
    tick(); expect_owner("err_c1", 2, 1'b0);
    HREADY = 1'b1;
    tick(); expect_owner("err_c2", 1, 1'b0);
    HRESP = 1'b0;

    // 6b. asynchronous reset in the middle of an INCR16
    hbusreq = 4'b0010; HTRANS = 2'd2; HBURST = 3'd7;
    tick(); expect_owner("rst_b1", 1, 1'b0);
    HTRANS = 2'd3;
    tick(); expect_owner("rst_b2", 1, 1'b0);
    #2 HRESETn = 1'b0;
    #1 expect_owner("rst_async", 0, 1'b0);
    tick(); expect_owner("rst_held", 0, 1'b0);
    HRESETn = 1'b1; HTRANS = 2'd0; HBURST = 3'd0;
    tick(); expect_owner("rst_after", 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
